// File: rtl/imm_instr_encoder.sv
// RV32I immediate encoder: range-checks a signed immediate and packs it with the
// register/funct fields into an instruction word, queued through a 2-entry FIFO.
module imm_instr_encoder #(
    parameter logic [31:0] NOP_WORD  = 32'h0000_0013,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_format,
    input  logic [6:0]           in_opcode,
    input  logic [4:0]           in_rd,
    input  logic [2:0]           in_funct3,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [31:0]          in_imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [1:0]           out_err_code,
    output logic [15:0]          enc_count,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;
    localparam logic [1:0] ERR_FMT   = 2'd3;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic signed [31:0] imm_p0;
    logic [31:0]        packed_p0;
    logic [31:0]        enc_instr_p0;
    logic [1:0]         enc_code_p0;
    logic               enc_err_p0;

    assign imm_p0 = in_imm;

    // Stage p0: combinational encode and check of the presented request
    always_comb begin
        packed_p0   = '0;
        enc_code_p0 = ERR_NONE;
        case (in_format)
            FMT_I: begin
                packed_p0 = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                if (!in_range(imm_p0, -32'sd2048, 32'sd2047)) enc_code_p0 = ERR_RANGE;
            end
            FMT_S: begin
                packed_p0 = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                if (!in_range(imm_p0, -32'sd2048, 32'sd2047)) enc_code_p0 = ERR_RANGE;
            end
            FMT_B: begin
                packed_p0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                if (in_imm[0])
                    enc_code_p0 = ERR_ALIGN;
                else if (!in_range(imm_p0, -32'sd4096, 32'sd4094))
                    enc_code_p0 = ERR_RANGE;
            end
            FMT_U: begin
                packed_p0 = {in_imm[31:12], in_rd, in_opcode};
                if (in_imm[11:0] != 12'd0) enc_code_p0 = ERR_ALIGN;
            end
            FMT_J: begin
                packed_p0 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                if (in_imm[0])
                    enc_code_p0 = ERR_ALIGN;
                else if (!in_range(imm_p0, -32'sd1048576, 32'sd1048574))
                    enc_code_p0 = ERR_RANGE;
            end
            default: enc_code_p0 = ERR_FMT;
        endcase
        enc_err_p0   = (enc_code_p0 != ERR_NONE);
        enc_instr_p0 = enc_err_p0 ? NOP_WORD : packed_p0;
    end

    logic [31:0] buf_instr_p1 [2];
    logic        buf_err_p1   [2];
    logic [1:0]  buf_code_p1  [2];
    logic [1:0]  cnt_p1;
    logic [1:0]  cnt_nxt;
    logic        in_ready_p1;
    logic        push;
    logic        pop;
    logic        wr_slot1;

    assign in_ready     = in_ready_p1;
    assign out_valid    = (cnt_p1 != 2'd0);
    assign out_instr    = buf_instr_p1[0];
    assign out_err      = buf_err_p1[0];
    assign out_err_code = buf_code_p1[0];

    assign push     = in_valid && in_ready_p1;
    assign pop      = out_valid && out_ready;
    // Slot 0 is always the head; a new word lands in slot 1 only if slot 0 stays occupied
    assign wr_slot1 = (cnt_p1 == 2'd1) && !pop;

    always_comb begin
        cnt_nxt = cnt_p1;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt_p1 + 2'd1;
            2'b01:   cnt_nxt = cnt_p1 - 2'd1;
            default: cnt_nxt = cnt_p1;
        endcase
    end

    // Stage p1: two-entry output buffer and transfer counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_p1          <= 2'd0;
            in_ready_p1     <= 1'b0;
            enc_count       <= '0;
            err_count       <= '0;
            buf_instr_p1[0] <= '0;
            buf_instr_p1[1] <= '0;
            buf_err_p1[0]   <= 1'b0;
            buf_err_p1[1]   <= 1'b0;
            buf_code_p1[0]  <= '0;
            buf_code_p1[1]  <= '0;
        end else begin
            cnt_p1      <= cnt_nxt;
            in_ready_p1 <= (cnt_nxt != 2'd2);
            if (pop) begin
                if (buf_err_p1[0]) err_count <= sat_inc(err_count);
                else               enc_count <= enc_count + 16'd1;
                buf_instr_p1[0] <= buf_instr_p1[1];
                buf_err_p1[0]   <= buf_err_p1[1];
                buf_code_p1[0]  <= buf_code_p1[1];
            end
            if (push) begin
                if (wr_slot1) begin
                    buf_instr_p1[1] <= enc_instr_p0;
                    buf_err_p1[1]   <= enc_err_p0;
                    buf_code_p1[1]  <= enc_code_p0;
                end else begin
                    buf_instr_p1[0] <= enc_instr_p0;
                    buf_err_p1[0]   <= enc_err_p0;
                    buf_code_p1[0]  <= enc_code_p0;
                end
            end
        end
    end

endmodule
